diff_frame_rx: RTL and testbench

//  Serial-line frame receiver for the differential link: recovers DATA_W-bit codes sent by the link

---
 rtl/diff_pkg.sv | 22 ++
 rtl/diff_frame_rx_if.sv | 23 ++
 rtl/diff_sync.sv | 20 ++
 rtl/diff_frame_rx.sv | 125 ++++++++++++
 tb/tb_diff_frame_rx.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/diff_pkg.sv
// Shared definitions for the differential serial link: code width, bit timing,
// receiver state encoding and the parity helper used by the transmitter and receiver.
package diff_pkg;

    localparam int DIFF_DATA_W       = 26;
    localparam int DIFF_CLKS_PER_BIT = 50;

    typedef enum logic [2:0] {
        RX_IDLE    = 3'd0,
        RX_START   = 3'd1,
        RX_DATA    = 3'd2,
        RX_PARITY  = 3'd3,
        RX_STOP    = 3'd4,
        RX_WAIT_HI = 3'd5
    } rx_state_e;

    // XOR reduction; zero-extension to 64 bits leaves the result unchanged.
    function automatic logic even_parity_bit(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/diff_frame_rx_if.sv
// Line-side and result signals of the frame receiver; master drives the line,
// slave is the receiver.
interface diff_frame_rx_if #(parameter int DATA_W = diff_pkg::DIFF_DATA_W);

    logic              listen_in;
    logic              data_in;
    logic [DATA_W-1:0] code_out;
    logic              new_code_out;
    logic              parity_err_out;
    logic              frame_err_out;
    logic [2:0]        state_out;

    modport master (
        output listen_in, data_in,
        input  code_out, new_code_out, parity_err_out, frame_err_out, state_out
    );

    modport slave (
        input  listen_in, data_in,
        output code_out, new_code_out, parity_err_out, frame_err_out, state_out
    );

endinterface

// File: rtl/diff_sync.sv
// Multi-flop synchroniser for the asynchronous serial line; resets to the idle-high level.
module diff_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_pipe;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) sync_pipe <= '1;
        else         sync_pipe <= {sync_pipe[STAGES-2:0], d};
    end

    assign q = sync_pipe[STAGES-1];

endmodule

// File: rtl/diff_frame_rx.sv
// Serial frame receiver: start, DATA_W bits LSB first, even parity, stop.
// Samples at mid-bit and publishes good codes with a single-cycle strobe.
module diff_frame_rx
    import diff_pkg::*;
#(
    parameter int DATA_W       = DIFF_DATA_W,
    parameter int CLKS_PER_BIT = DIFF_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic           clk_in,
    input  logic           rst_in,
    diff_frame_rx_if.slave bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] CNT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    rx_state_e         state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_bit;
    logic [DATA_W-1:0] code_q;
    logic              new_q, perr_q, ferr_q;

    logic line_sync, s;
    logic tick_mid, tick_end, parity_ok;
    logic cnt_clr, bit_clr, shift_en, par_en, code_ld, perr_set, ferr_set;

    diff_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d      (bus.data_in),
        .q      (line_sync)
    );

    // While the arbiter owns the line, the receiver sees a permanently idle line.
    assign s         = bus.listen_in ? line_sync : 1'b1;
    assign tick_mid  = (cnt == CNT_MID);
    assign tick_end  = (cnt == CNT_END);
    assign parity_ok = ~even_parity_bit(64'({par_bit, shreg}));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= RX_IDLE;
        else         state <= state_nxt;
    end

    // Counter is re-zeroed at the start mid-point, so every later tick_end lands mid-bit.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        bit_clr   = 1'b0;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        code_ld   = 1'b0;
        perr_set  = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_clr = 1'b1;
                if (!s) state_nxt = RX_START;
            end
            RX_START: if (tick_mid) begin
                cnt_clr   = 1'b1;
                bit_clr   = 1'b1;
                state_nxt = s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (tick_end) begin
                shift_en = 1'b1;
                if (bit_cnt == BIT_LAST) state_nxt = RX_PARITY;
            end
            RX_PARITY: if (tick_end) begin
                par_en    = 1'b1;
                state_nxt = RX_STOP;
            end
            RX_STOP: if (tick_end) begin
                if (!s) begin
                    ferr_set  = 1'b1;
                    state_nxt = RX_WAIT_HI;
                end else begin
                    code_ld   = parity_ok;
                    perr_set  = ~parity_ok;
                    state_nxt = RX_IDLE;
                end
            end
            RX_WAIT_HI: begin
                cnt_clr = 1'b1;
                if (s) state_nxt = RX_IDLE;
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            code_q  <= '0;
            new_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            cnt     <= (cnt_clr || tick_end) ? '0 : cnt + 1'b1;
            bit_cnt <= bit_clr ? '0 : (shift_en ? bit_cnt + 1'b1 : bit_cnt);
            if (shift_en) shreg   <= {s, shreg[DATA_W-1:1]};
            if (par_en)   par_bit <= s;
            if (code_ld)  code_q  <= shreg;
            new_q   <= code_ld;
            perr_q  <= perr_set;
            ferr_q  <= ferr_set;
        end
    end

    assign bus.code_out       = code_q;
    assign bus.new_code_out   = new_q;
    assign bus.parity_err_out = perr_q;
    assign bus.frame_err_out  = ferr_q;
    assign bus.state_out      = state;

endmodule

// File: tb/tb_diff_frame_rx.sv
// Directed bench for diff_frame_rx: frame table plus hand sequences for
// stop errors, glitches, back-to-back frames, async reset and listen gating.
module tb_diff_frame_rx;
    import diff_pkg::*;

    localparam int DW   = DIFF_DATA_W;
    localparam int CPB  = DIFF_CLKS_PER_BIT;
    localparam int SYNC = 2;

    logic clk_in = 1'b0;
    logic rst_in;

    diff_frame_rx_if #(.DATA_W(DW)) bus ();

    diff_frame_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int tests = 0;
    int fails = 0;

    int cyc = 0;
    int nc_cnt = 0, pe_cnt = 0, fe_cnt = 0, overlap = 0;
    int last_nc = 0, prev_nc = 0;
    logic [DW-1:0] codes[$];

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (rst_in === 1'b1) begin
            if (bus.new_code_out) begin
                nc_cnt++;
                prev_nc = last_nc;
                last_nc = cyc;
                codes.push_back(bus.code_out);
            end
            if (bus.parity_err_out) pe_cnt++;
            if (bus.frame_err_out)  fe_cnt++;
            if (int'(bus.new_code_out) + int'(bus.parity_err_out) + int'(bus.frame_err_out) > 1)
                overlap++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        bus.data_in = b;
        repeat (CPB) @(negedge clk_in);
    endtask

    task automatic send_body(input logic [DW-1:0] d, input bit flip);
        logic par;
        par = (^d) ^ flip;
        drive_bit(1'b0);
        for (int k = 0; k < DW; k++) drive_bit(d[k]);
        drive_bit(par);
    endtask

    typedef struct {
        logic [DW-1:0] data;
        bit            flip;
        logic          stop;
        int            exp_new;
        int            exp_perr;
        int            exp_ferr;
        logic [DW-1:0] exp_code;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs[NV];

    initial begin
        int b_nc, b_pe, b_fe, nonidle;

        vecs[0] = '{26'h2A55A5A, 1'b0, 1'b1, 1, 0, 0, 26'h2A55A5A};
        vecs[1] = '{26'h1234567, 1'b0, 1'b1, 1, 0, 0, 26'h1234567};
        vecs[2] = '{26'h0ABCDEF, 1'b1, 1'b1, 0, 1, 0, 26'h1234567};
        vecs[3] = '{26'h0155555, 1'b0, 1'b0, 0, 0, 1, 26'h1234567};
        vecs[4] = '{26'h3C3C3C3, 1'b1, 1'b0, 0, 0, 1, 26'h1234567};
        vecs[5] = '{26'h2A55A5A, 1'b0, 1'b1, 1, 0, 0, 26'h2A55A5A};
        vecs[6] = '{26'h2A55A5A, 1'b1, 1'b1, 0, 1, 0, 26'h2A55A5A};

        rst_in        = 1'b0;
        bus.listen_in = 1'b1;
        bus.data_in   = 1'b1;

        // Reset held with the line toggling
        repeat (10) begin
            @(negedge clk_in);
            bus.data_in = ~bus.data_in;
        end
        check("rst_code",  32'(bus.code_out), 32'h0);
        check("rst_new",   32'(bus.new_code_out), 32'h0);
        check("rst_perr",  32'(bus.parity_err_out), 32'h0);
        check("rst_ferr",  32'(bus.frame_err_out), 32'h0);
        check("rst_state", 32'(bus.state_out), 32'h0);
        bus.data_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (3 * CPB) @(negedge clk_in);
        check("post_rst_state", 32'(bus.state_out), 32'h0);
        check("post_rst_strobes", 32'(nc_cnt + pe_cnt + fe_cnt), 32'h0);

        // Frame table
        for (int i = 0; i < NV; i++) begin
            b_nc = nc_cnt; b_pe = pe_cnt; b_fe = fe_cnt;
            send_body(vecs[i].data, vecs[i].flip);
            drive_bit(vecs[i].stop);
            if (!vecs[i].stop) repeat (3) drive_bit(1'b0);
            bus.data_in = 1'b1;
            repeat (2 * CPB) @(negedge clk_in);
            check($sformatf("vec%0d_new", i),  32'(nc_cnt - b_nc), 32'(vecs[i].exp_new));
            check($sformatf("vec%0d_perr", i), 32'(pe_cnt - b_pe), 32'(vecs[i].exp_perr));
            check($sformatf("vec%0d_ferr", i), 32'(fe_cnt - b_fe), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_code", i), 32'(bus.code_out), 32'(vecs[i].exp_code));
            check($sformatf("vec%0d_idle", i), 32'(bus.state_out), 32'h0);
        end

        // Stop bit low, line held low: WAIT_HI until it returns high
        b_fe = fe_cnt;
        send_body(26'h0155555, 1'b0);
        bus.data_in = 1'b0;
        repeat (CPB) @(negedge clk_in);
        check("hold_ferr", 32'(fe_cnt - b_fe), 32'h1);
        check("hold_state_a", 32'(bus.state_out), 32'h5);
        repeat (2 * CPB) @(negedge clk_in);
        check("hold_state_b", 32'(bus.state_out), 32'h5);
        bus.data_in = 1'b1;
        repeat (SYNC + 2) @(negedge clk_in);
        check("hold_release", 32'(bus.state_out), 32'h0);
        repeat (2 * CPB) @(negedge clk_in);

        // Short low glitch on the idle line
        b_nc = nc_cnt; b_pe = pe_cnt; b_fe = fe_cnt;
        bus.data_in = 1'b0;
        repeat (SYNC + 2) @(negedge clk_in);
        check("glitch_start", 32'(bus.state_out), 32'h1);
        repeat (CPB / 4 - (SYNC + 2)) @(negedge clk_in);
        bus.data_in = 1'b1;
        repeat (CPB) @(negedge clk_in);
        check("glitch_idle", 32'(bus.state_out), 32'h0);
        check("glitch_strobes", 32'((nc_cnt - b_nc) + (pe_cnt - b_pe) + (fe_cnt - b_fe)), 32'h0);

        // Back-to-back frames with no idle gap
        codes.delete();
        b_nc = nc_cnt;
        send_body(26'h0000001, 1'b0);
        drive_bit(1'b1);
        send_body(26'h3FFFFFF, 1'b0);
        drive_bit(1'b1);
        repeat (2 * CPB) @(negedge clk_in);
        check("b2b_count", 32'(nc_cnt - b_nc), 32'h2);
        check("b2b_qsize", 32'(codes.size()), 32'h2);
        if (codes.size() >= 2) begin
            check("b2b_code0", 32'(codes[0]), 32'h0000001);
            check("b2b_code1", 32'(codes[1]), 32'h3FFFFFF);
            check("b2b_spacing", 32'(last_nc - prev_nc), 32'(CPB * 29));
        end

        // Async reset while receiving data bits
        b_nc = nc_cnt; b_pe = pe_cnt; b_fe = fe_cnt;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        check("arst_in_data", 32'(bus.state_out), 32'h2);
        rst_in = 1'b0;
        #1;
        check("arst_state", 32'(bus.state_out), 32'h0);
        check("arst_code", 32'(bus.code_out), 32'h0);
        repeat (3) @(negedge clk_in);
        bus.data_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (2 * CPB) @(negedge clk_in);
        check("arst_after_state", 32'(bus.state_out), 32'h0);
        check("arst_after_strobes", 32'((nc_cnt - b_nc) + (pe_cnt - b_pe) + (fe_cnt - b_fe)), 32'h0);

        // listen_in low with the line held low
        b_nc = nc_cnt; b_pe = pe_cnt; b_fe = fe_cnt;
        nonidle = 0;
        bus.listen_in = 1'b0;
        bus.data_in   = 1'b0;
        repeat (3 * CPB) begin
            @(negedge clk_in);
            if (bus.state_out != 3'd0) nonidle++;
        end
        check("listen_nonidle", 32'(nonidle), 32'h0);
        bus.data_in = 1'b1;
        repeat (SYNC + 2) @(negedge clk_in);
        bus.listen_in = 1'b1;
        repeat (CPB) @(negedge clk_in);
        check("listen_state", 32'(bus.state_out), 32'h0);
        check("listen_strobes", 32'((nc_cnt - b_nc) + (pe_cnt - b_pe) + (fe_cnt - b_fe)), 32'h0);

        check("strobe_overlap", 32'(overlap), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
